// File: rtl/day_3_line_parser.sv
// day_3_line_parser: packs each ASCII line of decimal digits into one binary word,
// emitted on an AXI-stream master with the file's tlast carried to the final word.
module day_3_line_parser #(
    parameter int OUTPUTWIDTH = 64,
    parameter int MAX_DIGITS  = 19
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    output logic [OUTPUTWIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   bad_char_o,
    output logic                   overflow_o,
    output logic [15:0]            lines_o
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);

    // log2(10) ~= 3.3219: the accumulator must hold MAX_DIGITS nines without wrapping
    if (MAX_DIGITS * 33219 > OUTPUTWIDTH * 10000) begin : g_width_check
        $error("OUTPUTWIDTH too narrow for MAX_DIGITS");
    end

    typedef enum logic {S_ACCUM, S_EMIT} state_t;
    state_t state, state_next;

    logic [OUTPUTWIDTH-1:0] acc, acc_next;
    logic [CW-1:0]          digit_cnt;
    logic accept, is_digit, is_lf, is_cr, digit_ok, end_line, emit_done;

    assign accept    = (state == S_ACCUM) && s_axis_tvalid;
    assign is_digit  = (s_axis_tdata >= 8'h30) && (s_axis_tdata <= 8'h39);
    assign is_lf     = s_axis_tdata == 8'h0A;
    assign is_cr     = s_axis_tdata == 8'h0D;
    assign digit_ok  = is_digit && (digit_cnt < MAX_CNT);
    assign acc_next  = digit_ok ? (acc << 3) + (acc << 1) + {{(OUTPUTWIDTH-4){1'b0}}, s_axis_tdata[3:0]} : acc;
    assign end_line  = accept && (s_axis_tlast || (is_lf && digit_cnt != '0));
    assign emit_done = (state == S_EMIT) && m_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_ACCUM;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == S_ACCUM) state_next = end_line ? S_EMIT : S_ACCUM;
        else                  state_next = m_axis_tready ? S_ACCUM : S_EMIT;
    end

    always_comb begin
        s_axis_tready = state == S_ACCUM;
        m_axis_tvalid = state == S_EMIT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            digit_cnt    <= '0;
            m_axis_tdata <= '0;
            m_axis_tlast <= 1'b0;
            bad_char_o   <= 1'b0;
            overflow_o   <= 1'b0;
            lines_o      <= '0;
        end else begin
            if (emit_done) begin
                acc       <= '0;
                digit_cnt <= '0;
                lines_o   <= lines_o + 16'd1;
            end else if (accept) begin
                acc <= acc_next;
                if (digit_ok) digit_cnt <= digit_cnt + CW'(1);
            end
            if (end_line) begin
                m_axis_tdata <= acc_next;
                m_axis_tlast <= s_axis_tlast;
            end
            if (accept && is_digit && !digit_ok) overflow_o <= 1'b1;
            if (accept && !is_digit && !is_lf && !is_cr) bad_char_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_day_3_line_parser.sv
// tb_day_3_line_parser: table vectors, hand-written corner sequences and randomized
// streams checked against a line-level reference model.
module tb_day_3_line_parser;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic        bad_char;
    logic        overflow;
    logic [15:0] lines;

    always #5 clk = ~clk;

    day_3_line_parser dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
        .bad_char_o(bad_char), .overflow_o(overflow), .lines_o(lines)
    );

    typedef struct {
        logic [63:0] w;
        logic        l;
    } word_t;

    typedef struct {
        string       txt;
        int          n;
        logic [63:0] w0, w1, w2, w3;
        logic [3:0]  l;
        bit          bad;
        bit          ovf;
    } vec_t;

    word_t got_q[$];
    word_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    bit    bp_rand = 0;
    bit    bp_hold = 0;
    bit    exp_bad, exp_ovf;

    // Inputs change 1 time unit after the rising edge; outputs are observed on the falling edge.
    always @(posedge clk) begin
        #1;
        m_tready = bp_rand ? ($urandom_range(0, 3) != 0) : !bp_hold;
    end

    always @(negedge clk)
        if (rst_n && m_tvalid && m_tready) got_q.push_back('{m_tdata, m_tlast});

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        s_tvalid = 0;
        s_tlast  = 0;
        rst_n    = 0;
        repeat (2) begin @(posedge clk); #1; end
        got_q.delete();
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic check_reset(input string tag);
        @(negedge clk);
        check({tag, "_tvalid"}, m_tvalid, 0);
        check({tag, "_tdata"}, m_tdata, 0);
        check({tag, "_tlast"}, m_tlast, 0);
        check({tag, "_bad"}, bad_char, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_lines"}, lines, 0);
        check({tag, "_sready"}, s_tready, 1);
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input byte b, input bit last);
        int k = 0;
        s_tdata  = b;
        s_tvalid = 1;
        s_tlast  = last;
        @(negedge clk);
        while (!s_tready && k < 200) begin @(negedge clk); k++; end
        if (!s_tready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got tready=0 expected 1 within 200 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic send_seq(input byte q[$], input bit last);
        for (int i = 0; i < q.size(); i++) send_byte(q[i], last && (i == q.size() - 1));
        s_tvalid = 0;
        s_tlast  = 0;
    endtask

    task automatic drain_check(input string tag);
        int k = 0;
        while ((got_q.size() < exp_q.size() || m_tvalid) && k < 300) begin @(posedge clk); #1; k++; end
        @(negedge clk);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_word%0d", tag, i), got_q[i].w, exp_q[i].w);
            check($sformatf("%s_last%0d", tag, i), got_q[i].l, exp_q[i].l);
        end
        check({tag, "_lines"}, lines, 64'(exp_q.size()));
        check({tag, "_bad"}, bad_char, exp_bad);
        check({tag, "_ovf"}, overflow, exp_ovf);
        @(posedge clk); #1;
    endtask

    // Reference: a line's word is its first 19 digits read as a decimal number.
    task automatic model(input byte q[$]);
        byte         digs[$];
        logic [63:0] v;
        exp_q.delete();
        exp_bad = 0;
        exp_ovf = 0;
        for (int i = 0; i < q.size(); i++) begin
            bit last = i == q.size() - 1;
            byte b = q[i];
            if (b >= "0" && b <= "9") begin
                if (digs.size() < 19) digs.push_back(b);
                else exp_ovf = 1;
            end else if (b != 8'h0A && b != 8'h0D) exp_bad = 1;
            if (last || (b == 8'h0A && digs.size() > 0)) begin
                v = 0;
                foreach (digs[j]) v = v * 10 + 64'(digs[j] - 8'h30);
                exp_q.push_back('{v, last});
                digs.delete();
            end
        end
    endtask

    initial begin
        vec_t vecs[8];
        byte  q[$];
        vecs[0] = '{"987654321111111\n", 1, 64'd987654321111111, 0, 0, 0, 4'b0001, 0, 0};
        vecs[1] = '{"12\n34\n\n5", 3, 64'd12, 64'd34, 64'd5, 0, 4'b0100, 0, 0};
        vecs[2] = '{"818181911112111\r\n\n", 2, 64'd818181911112111, 64'd0, 0, 0, 4'b0010, 0, 0};
        vecs[3] = '{"999999999999999999999\n", 1, 64'd9999999999999999999, 0, 0, 0, 4'b0001, 0, 1};
        vecs[4] = '{"12x3\n", 1, 64'd123, 0, 0, 0, 4'b0001, 1, 0};
        vecs[5] = '{"5\r", 1, 64'd5, 0, 0, 0, 4'b0001, 0, 0};
        vecs[6] = '{"0012\n", 1, 64'd12, 0, 0, 0, 4'b0001, 0, 0};
        vecs[7] = '{"987654321111111\n811111111111119\n234234234234278\n818181911112111\n", 4,
                    64'd987654321111111, 64'd811111111111119, 64'd234234234234278, 64'd818181911112111,
                    4'b1000, 0, 0};

        do_reset();
        check_reset("rst");

        foreach (vecs[i]) begin
            logic [63:0] ws[4];
            do_reset();
            q.delete();
            for (int c = 0; c < vecs[i].txt.len(); c++) q.push_back(vecs[i].txt[c]);
            ws = '{vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].w3};
            exp_q.delete();
            for (int j = 0; j < vecs[i].n; j++) exp_q.push_back('{ws[j], vecs[i].l[j]});
            exp_bad = vecs[i].bad;
            exp_ovf = vecs[i].ovf;
            send_seq(q, 1);
            drain_check($sformatf("vec%0d", i));
        end

        begin
            bit stable = 1;
            bp_hold = 1;
            do_reset();
            q = '{"4", "2", 8'h0A};
            send_seq(q, 1);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (!(m_tvalid && m_tdata == 64'd42 && m_tlast && !s_tready && !m_tready)) stable = 0;
            end
            check("hold_stable", stable, 1);
            check("hold_no_word", got_q.size(), 0);
            @(posedge clk); #1;
            bp_hold = 0;
            exp_q = '{'{64'd42, 1'b1}};
            exp_bad = 0;
            exp_ovf = 0;
            drain_check("hold");
        end

        do_reset();
        q = '{"1", "x", "2", "3"};
        send_seq(q, 0);
        @(negedge clk);
        check("pre_rst_bad", bad_char, 1);
        @(posedge clk); #1;
        rst_n = 0;
        check_reset("midrst");
        rst_n = 1;
        @(posedge clk); #1;
        q = '{"4", "5", 8'h0A};
        send_seq(q, 1);
        exp_q = '{'{64'd45, 1'b1}};
        exp_bad = 0;
        exp_ovf = 0;
        drain_check("midrst_after");

        bp_rand = 1;
        for (int it = 0; it < 15; it++) begin
            int nl = $urandom_range(1, 6);
            q.delete();
            for (int l = 0; l < nl; l++) begin
                int len = $urandom_range(0, 22);
                for (int c = 0; c < len; c++) begin
                    int r = $urandom_range(0, 99);
                    q.push_back(r < 85 ? 8'(8'h31 + $urandom_range(0, 8)) : r < 92 ? 8'h30 : r < 96 ? 8'h0D : 8'h61);
                end
                if (l != nl - 1 || $urandom_range(0, 1) == 1) q.push_back(8'h0A);
            end
            if (q.size() == 0) q.push_back(8'h0A);
            do_reset();
            model(q);
            send_seq(q, 1);
            drain_check($sformatf("rnd%0d", it));
        end
        bp_rand = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
